scope_capture_ctrl: RTL and testbench

Trigger and acquisition controller for the oscilloscope front end. It watches the 10-bit ADC sample stream, detects the trigger-level crossing, and writes one screen-width frame into an external sample RAM, which is used as a ring buffer. The frame holds a fixed pre-trigger history. The controller then hands the frame to the display side and waits for a frame acknowledge before re-arming. The display converts each stored sample with the data-to-pixel mapping and draws the trigger marker at the latched level.

---
 rtl/scope_capture_ctrl.sv | 177 +++++++++++++++++
 tb/tb_scope_capture_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope trigger/acquisition controller: captures one frame around a
// trigger-level crossing into a ring-buffer sample RAM, then holds it for display.
module scope_capture_ctrl #(
   parameter  int unsigned DEPTH        = 640,
   parameter  int unsigned ADDR_W       = 10,
   parameter  int unsigned PRE_TRIG     = 320,
   parameter  int unsigned AUTO_TIMEOUT = 4096,
   localparam int unsigned DATA_W       = 10
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_sample,
   input  logic              i_sample_valid,
   input  logic [DATA_W-1:0] i_level,
   input  logic              i_falling,
   input  logic [1:0]        i_mode,
   input  logic              i_arm,
   input  logic              i_stop,
   input  logic              i_frame_ack,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   output logic              o_frame_ready,
   output logic [ADDR_W-1:0] o_frame_start,
   output logic              o_triggered,
   output logic [DATA_W-1:0] o_level_latched,
   output logic              o_busy
);

   localparam int unsigned POST_N  = DEPTH - PRE_TRIG - 1;
   localparam int unsigned CNT_MAX = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned SUM_W   = ADDR_W + 1;

   localparam logic [1:0] MODE_AUTO   = 2'd1;
   localparam logic [1:0] MODE_SINGLE = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRETRIG = 3'd1,
      S_ARMED   = 3'd2,
      S_POST    = 3'd3,
      S_HOLD    = 3'd4
   } state_t;

   // With no pre-trigger history the acquisition starts armed; with no
   // post-trigger samples the trigger sample completes the frame.
   localparam state_t ACQ_START = (PRE_TRIG == 0) ? S_ARMED : S_PRETRIG;
   localparam state_t TRIG_NEXT = (POST_N == 0)   ? S_HOLD  : S_POST;

   state_t state;
   state_t next_state;

   logic [ADDR_W-1:0] ptr;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] prev_sample;
   logic              prev_valid;
   logic              falling_q;
   logic [1:0]        mode_q;

   logic              rise_hit;
   logic              fall_hit;
   logic              edge_hit;
   logic              timeout_hit;
   logic              trig_fire;

   logic              capturing;
   logic              wr_en_d;
   logic              busy_d;
   logic              ready_d;
   logic              enter_acq;
   logic [SUM_W-1:0]  frame_sum;
   logic [ADDR_W-1:0] frame_start_d;
   logic [ADDR_W-1:0] ptr_next;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= next_state;
   end

   // Trigger qualification on the current accepted sample
   always_comb begin
      rise_hit    = prev_valid && (prev_sample < o_level_latched) && (i_sample >= o_level_latched);
      fall_hit    = prev_valid && (prev_sample > o_level_latched) && (i_sample <= o_level_latched);
      edge_hit    = i_sample_valid && (falling_q ? fall_hit : rise_hit);
      timeout_hit = i_sample_valid && (mode_q == MODE_AUTO) && (cnt == CNT_W'(AUTO_TIMEOUT - 1));
      trig_fire   = (state == S_ARMED) && (edge_hit || timeout_hit);
   end

   // Next-state logic; stop overrides every other request
   always_comb begin
      next_state = state;
      if (i_stop) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (i_arm || (i_mode != MODE_SINGLE)) next_state = ACQ_START;
            S_PRETRIG: if (i_sample_valid && (cnt == CNT_W'(PRE_TRIG - 1))) next_state = S_ARMED;
            S_ARMED:   if (trig_fire) next_state = TRIG_NEXT;
            S_POST:    if (i_sample_valid && (cnt == CNT_W'(POST_N - 1))) next_state = S_HOLD;
            S_HOLD:    if (i_frame_ack) next_state = (mode_q == MODE_SINGLE) ? S_IDLE : ACQ_START;
            default:   next_state = S_IDLE;
         endcase
      end
   end

   // Next values of the registered outputs and pointer arithmetic
   always_comb begin
      capturing     = (state == S_PRETRIG) || (state == S_ARMED) || (state == S_POST);
      wr_en_d       = capturing && i_sample_valid && !i_stop;
      busy_d        = (next_state == S_PRETRIG) || (next_state == S_ARMED) || (next_state == S_POST);
      ready_d       = (next_state == S_HOLD);
      enter_acq     = ((state == S_IDLE) || (state == S_HOLD)) &&
                      ((next_state == S_PRETRIG) || (next_state == S_ARMED));
      frame_sum     = SUM_W'(ptr) + SUM_W'(DEPTH - PRE_TRIG);
      frame_start_d = (frame_sum >= SUM_W'(DEPTH)) ? ADDR_W'(frame_sum - SUM_W'(DEPTH))
                                                   : ADDR_W'(frame_sum);
      ptr_next      = (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
   end

   // Datapath registers: write port, counters, config latch, frame descriptor
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_wr_en         <= 1'b0;
         o_wr_addr       <= '0;
         o_wr_data       <= '0;
         o_frame_ready   <= 1'b0;
         o_frame_start   <= '0;
         o_triggered     <= 1'b0;
         o_level_latched <= '0;
         o_busy          <= 1'b0;
         ptr             <= '0;
         cnt             <= '0;
         prev_sample     <= '0;
         prev_valid      <= 1'b0;
         falling_q       <= 1'b0;
         mode_q          <= 2'd0;
      end else begin
         o_wr_en       <= wr_en_d;
         o_busy        <= busy_d;
         o_frame_ready <= ready_d;

         if (wr_en_d) begin
            o_wr_addr <= ptr;
            o_wr_data <= i_sample;
            ptr       <= ptr_next;
         end

         // Per-state sample count restarts on every state change
         if (next_state != state)  cnt <= '0;
         else if (i_sample_valid)  cnt <= cnt + CNT_W'(1);

         // Previous-sample history only spans samples accepted while armed
         if ((state == S_ARMED) && (next_state == S_ARMED)) begin
            if (i_sample_valid) begin
               prev_valid  <= 1'b1;
               prev_sample <= i_sample;
            end
         end else begin
            prev_valid <= 1'b0;
         end

         if (enter_acq) begin
            o_level_latched <= i_level;
            falling_q       <= i_falling;
            mode_q          <= i_mode;
         end

         if (trig_fire && !i_stop) begin
            o_frame_start <= frame_start_d;
            o_triggered   <= edge_hit;
         end
      end
   end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Scoreboard bench for scope_capture_ctrl with a sample-list reference model.
module tb_scope_capture_ctrl;

   localparam int unsigned DEPTH        = 16;
   localparam int unsigned ADDR_W       = 5;
   localparam int unsigned PRE_TRIG     = 4;
   localparam int unsigned AUTO_TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [9:0]        sample = '0;
   logic              valid = 1'b0;
   logic [9:0]        level = '0;
   logic              falling = 1'b0;
   logic [1:0]        mode = 2'd0;
   logic              arm = 1'b0;
   logic              stop = 1'b0;
   logic              ack = 1'b0;
   logic              o_wr_en;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [9:0]        o_wr_data;
   logic              o_frame_ready;
   logic [ADDR_W-1:0] o_frame_start;
   logic              o_triggered;
   logic [9:0]        o_level_latched;
   logic              o_busy;

   always #5 clk = ~clk;

   scope_capture_ctrl #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRE_TRIG(PRE_TRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_sample_valid(valid),
      .i_level(level), .i_falling(falling), .i_mode(mode), .i_arm(arm),
      .i_stop(stop), .i_frame_ack(ack), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data), .o_frame_ready(o_frame_ready), .o_frame_start(o_frame_start),
      .o_triggered(o_triggered), .o_level_latched(o_level_latched), .o_busy(o_busy)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [9:0]        data;
   } wr_t;

   typedef struct {
      logic              busy;
      logic              ready;
      logic              wr_en;
      logic [9:0]        level;
      logic [ADDR_W-1:0] start;
      logic              trig;
      bit                chk_frame;
      bit                chk_rst;
   } st_t;

   wr_t wq[$];
   st_t sq[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   // Stimulus-side configuration, applied to the DUT only at the drive point
   logic [9:0] cfg_level = 10'd512;
   logic       cfg_fall  = 1'b0;
   logic [1:0] cfg_mode  = 2'd0;

   // Reference model: an acquisition is the list of samples accepted since it began
   typedef enum {M_IDLE, M_CAP, M_HOLD} mphase_t;
   mphase_t           ph = M_IDLE;
   int unsigned       wr_total = 0;
   int                acq[$];
   int                trig_idx = 0;
   bit                trig_found = 0;
   logic [9:0]        m_level = '0;
   logic              m_fall = 1'b0;
   logic [1:0]        m_mode = 2'd0;
   logic [ADDR_W-1:0] m_start = '0;
   logic              m_trig = 1'b0;

   task automatic start_acq();
      m_level    = level;
      m_fall     = falling;
      m_mode     = mode;
      acq.delete();
      trig_found = 0;
      ph         = M_CAP;
   endtask

   task automatic eval_trigger(input logic [ADDR_W-1:0] addr);
      int idx;
      int apos;
      int p;
      int c;
      int lvl;
      bit hit;
      idx = acq.size() - 1;
      lvl = int'(m_level);
      hit = 0;
      if (!trig_found && idx >= int'(PRE_TRIG)) begin
         apos = idx - int'(PRE_TRIG);
         if (apos >= 1) begin
            p   = acq[idx-1];
            c   = acq[idx];
            hit = m_fall ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl);
         end
         if (hit || (m_mode == 2'd1 && apos == int'(AUTO_TIMEOUT) - 1)) begin
            trig_found = 1;
            trig_idx   = idx;
            m_trig     = hit;
            m_start    = ADDR_W'((int'(addr) + int'(DEPTH) - int'(PRE_TRIG)) % int'(DEPTH));
         end
      end
   endtask

   task automatic model_step();
      st_t s;
      wr_t w;
      bit  wr;
      bit  is_rst;
      wr     = 0;
      is_rst = 0;
      if (rst) begin
         ph = M_IDLE; wr_total = 0; m_level = '0; m_fall = 1'b0; m_mode = 2'd0;
         m_start = '0; m_trig = 1'b0; acq.delete(); trig_found = 0; is_rst = 1;
      end else if (stop) begin
         ph = M_IDLE;
      end else begin
         case (ph)
            M_IDLE: if (arm || mode != 2'd2) start_acq();
            M_CAP: if (valid) begin
               w.addr = ADDR_W'(wr_total % DEPTH);
               w.data = sample;
               wq.push_back(w);
               wr = 1;
               acq.push_back(int'(sample));
               eval_trigger(w.addr);
               wr_total++;
               if (trig_found && acq.size() == trig_idx + int'(DEPTH - PRE_TRIG)) ph = M_HOLD;
            end
            M_HOLD: if (ack) begin
               if (m_mode == 2'd2) ph = M_IDLE;
               else start_acq();
            end
            default: ph = M_IDLE;
         endcase
      end
      s.busy      = (ph == M_CAP);
      s.ready     = (ph == M_HOLD);
      s.wr_en     = wr;
      s.level     = m_level;
      s.start     = m_start;
      s.trig      = m_trig;
      s.chk_frame = (ph == M_HOLD) || is_rst;
      s.chk_rst   = is_rst;
      sq.push_back(s);
   endtask

   // One clock of stimulus, driven on the falling edge
   task automatic cyc(input bit r, input bit st, input bit a, input bit k,
                      input bit v, input logic [9:0] smp);
      @(negedge clk);
      rst = r; stop = st; arm = a; ack = k; valid = v; sample = smp;
      level = cfg_level; falling = cfg_fall; mode = cfg_mode;
      model_step();
   endtask

   task automatic feed(input bit v, input logic [9:0] smp);
      cyc(0, 0, 0, 0, v, smp);
   endtask

   task automatic feed_gap(input logic [9:0] smp);
      int g;
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) feed(0, 10'd1023);
      feed(1, smp);
   endtask

   task automatic fill_to_hold(input int gap_pct);
      int guard;
      guard = 0;
      while (ph != M_HOLD && guard < 400) begin
         feed(($urandom_range(0, 99) >= gap_pct), 10'($urandom_range(0, 1023)));
         guard++;
      end
      if (ph != M_HOLD) begin
         n_cmp++; n_bad++;
         $display("FAIL fill_timeout: frame not complete after %0d cycles (required complete)", guard);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a write, and every cycle for status
   initial begin : monitor
      wr_t w;
      st_t s;
      forever begin
         @(posedge clk);
         #1;
         if (o_wr_en === 1'b1) begin
            n_cmp++;
            if (wq.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write t=%0t addr=%0d data=%0d required=no write",
                        $time, o_wr_addr, o_wr_data);
            end else begin
               w = wq.pop_front();
               if (o_wr_addr !== w.addr || o_wr_data !== w.data) begin
                  n_bad++;
                  $display("FAIL write t=%0t addr=%0d data=%0d required addr=%0d data=%0d",
                           $time, o_wr_addr, o_wr_data, w.addr, w.data);
               end
            end
         end
         if (sq.size() > 0) begin
            s = sq.pop_front();
            n_cmp++;
            if (o_busy !== s.busy || o_frame_ready !== s.ready || o_wr_en !== s.wr_en ||
                o_level_latched !== s.level) begin
               n_bad++;
               $display("FAIL status t=%0t busy=%b ready=%b wr_en=%b level=%0d required busy=%b ready=%b wr_en=%b level=%0d",
                        $time, o_busy, o_frame_ready, o_wr_en, o_level_latched,
                        s.busy, s.ready, s.wr_en, s.level);
            end
            if (s.chk_frame) begin
               n_cmp++;
               if (o_frame_start !== s.start || o_triggered !== s.trig) begin
                  n_bad++;
                  $display("FAIL frame t=%0t start=%0d triggered=%b required start=%0d triggered=%b",
                           $time, o_frame_start, o_triggered, s.start, s.trig);
               end
            end
            if (s.chk_rst) begin
               n_cmp++;
               if (o_wr_addr !== '0 || o_wr_data !== '0) begin
                  n_bad++;
                  $display("FAIL reset_wr t=%0t addr=%0d data=%0d required 0/0",
                           $time, o_wr_addr, o_wr_data);
               end
            end
         end
      end
   end

   initial begin : driver
      int npad;
      int guard;
      logic [9:0] seq2 [8];
      logic [9:0] seq6 [8];

      // Reset
      repeat (2) cyc(1, 0, 0, 0, 1, 10'd77);

      // Rising trigger on a ramp: edge 500->600 at address 6, frame start 2
      cfg_level = 10'd512; cfg_fall = 1'b0; cfg_mode = 2'd0;
      feed(0, 10'd0);
      for (int k = 0; k <= 10; k++) feed(1, 10'(k * 100));
      fill_to_hold(0);
      repeat (4) feed(1, 10'($urandom_range(0, 1023)));

      // Re-arm falling and park the write pointer at 14 via stop in single mode
      cfg_fall = 1'b1;
      cyc(0, 0, 0, 1, 1, 10'd900);
      npad = (14 - int'(wr_total % DEPTH) + int'(DEPTH)) % int'(DEPTH);
      for (int i = 0; i < npad; i++) feed(1, 10'd900);
      cfg_mode = 2'd2;
      cyc(0, 1, 0, 0, 1, 10'd900);
      repeat (3) feed(1, 10'd900);

      // Falling edge across the ring wrap; first armed sample below level does not trigger
      cfg_mode = 2'd0;
      feed(0, 10'd0);
      seq2 = '{10'd1000, 10'd900, 10'd800, 10'd700, 10'd300, 10'd200, 10'd800, 10'd400};
      for (int i = 0; i < 8; i++) feed(1, seq2[i]);
      fill_to_hold(20);
      cfg_mode = 2'd1;
      cfg_fall = 1'b0;
      feed(1, 10'd5);
      cyc(0, 0, 0, 1, 1, 10'd100);

      // Auto timeout on a flat signal, then automatic re-arm
      guard = 0;
      while (ph != M_HOLD && guard < 100) begin
         feed(1, 10'd100);
         guard++;
      end
      repeat (3) feed(1, 10'd100);
      cyc(0, 0, 0, 1, 0, 10'd100);
      repeat (3) feed(1, 10'd100);

      // Single mode: stop, stay idle, arm, capture, ack back to idle
      cfg_mode = 2'd2;
      cyc(0, 1, 0, 0, 1, 10'd100);
      repeat (6) feed(1, 10'($urandom_range(0, 1023)));
      cyc(0, 0, 1, 0, 1, 10'd100);
      fill_to_hold(10);
      repeat (2) feed(1, 10'd9);
      cyc(0, 0, 0, 1, 1, 10'd9);
      repeat (10) feed(1, 10'($urandom_range(0, 1023)));
      cfg_mode = 2'd0;
      cyc(0, 0, 1, 0, 1, 10'd100);

      // Stop in POST together with a sample and an ack; then reset while armed
      guard = 0;
      while (!(ph == M_CAP && trig_found) && guard < 400) begin
         feed(1, 10'($urandom_range(0, 1023)));
         guard++;
      end
      repeat (2) feed(1, 10'd600);
      cyc(0, 1, 0, 1, 1, 10'd600);
      feed(1, 10'd100);
      repeat (6) feed(1, 10'd100);
      cyc(1, 0, 0, 0, 1, 10'd300);

      // Equal-to-level and just-below-level edges with valid gaps
      cyc(0, 0, 0, 0, 0, 10'd0);
      seq6 = '{10'd100, 10'd100, 10'd100, 10'd100, 10'd512, 10'd512, 10'd511, 10'd512};
      for (int i = 0; i < 8; i++) feed_gap(seq6[i]);
      fill_to_hold(40);
      repeat (2) feed(0, 10'd0);
      cyc(0, 0, 0, 1, 0, 10'd0);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 49) == 0) cfg_mode  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) cfg_level = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 29) == 0) cfg_fall  = 1'($urandom_range(0, 1));
         cyc(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 59) == 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 1023))
                                         : 10'(int'(cfg_level) + $urandom_range(0, 6) - 3));
      end

      repeat (3) feed(0, 10'd0);
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (wq.size() != 0 || sq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: writes pending=%0d status pending=%0d required 0/0",
                  wq.size(), sq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
